// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide over 32 iterations, with results landing in the HI/LO registers.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state;
   state_t      next_state;
   logic [1:0]  op_r;
   logic        sign_a;
   logic        sign_b;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [63:0] acc;
   logic [4:0]  cnt;

   logic [32:0] mul_sum;
   logic [63:0] mul_step;
   logic [32:0] div_trial;
   logic [32:0] div_diff;
   logic        div_ge;
   logic [31:0] div_rem;
   logic [63:0] div_step;

   logic        is_signed;
   logic [63:0] prod;
   logic [31:0] fix_hi;
   logic [31:0] fix_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (cnt == 5'd31) next_state = FIX;
         FIX:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   // One iteration of each algorithm; the counter selects the operand bit so the
   // latched magnitudes stay intact for the divide-by-zero HI value.
   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + (mag_b[cnt] ? {1'b0, mag_a} : 33'd0);
      mul_step  = {mul_sum, acc[31:1]};
      div_trial = {acc[63:32], mag_a[5'd31 - cnt]};
      div_diff  = div_trial - {1'b0, mag_b};
      div_ge    = ~div_diff[32];
      div_rem   = div_ge ? div_diff[31:0] : div_trial[31:0];
      div_step  = {div_rem, acc[30:0], div_ge};
   end

   always_comb begin
      is_signed = ~op_r[0];
      prod      = (is_signed && (sign_a ^ sign_b)) ? -acc : acc;
      fix_hi    = prod[63:32];
      fix_lo    = prod[31:0];
      if (op_r[1]) begin
         if (mag_b == 32'd0) begin
            fix_lo = 32'hFFFF_FFFF;
            fix_hi = (is_signed && sign_a) ? -mag_a : mag_a;
         end else begin
            fix_lo = (is_signed && (sign_a ^ sign_b)) ? -acc[31:0] : acc[31:0];
            fix_hi = (is_signed && sign_a) ? -acc[63:32] : acc[63:32];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r   <= 2'd0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mag_a  <= 32'd0;
         mag_b  <= 32'd0;
         acc    <= 64'd0;
         cnt    <= 5'd0;
         hi     <= 32'd0;
         lo     <= 32'd0;
         done   <= 1'b0;
      end else begin
         done <= (state == FIX);
         case (state)
            IDLE: begin
               if (start) begin
                  op_r   <= op;
                  sign_a <= rs_val[31];
                  sign_b <= rt_val[31];
                  mag_a  <= (!op[0] && rs_val[31]) ? -rs_val : rs_val;
                  mag_b  <= (!op[0] && rt_val[31]) ? -rt_val : rt_val;
                  acc    <= 64'd0;
                  cnt    <= 5'd0;
               end else begin
                  if (mthi) hi <= wdata;
                  if (mtlo) lo <= wdata;
               end
            end
            RUN: begin
               acc <= op_r[1] ? div_step : mul_step;
               cnt <= cnt + 5'd1;
            end
            FIX: begin
               hi <= fix_hi;
               lo <= fix_lo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: hand-computed results, latency, busy/done
// framing, ignored requests while busy, MTHI/MTLO, and asynchronous abort.
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc;
   int busy_cnt;
   int done_cnt;
   int done_idx;

   muldiv_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .rs_val(rs_val),
      .rt_val(rt_val),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge just after the start edge.
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts falling edges until done is seen (bounded); returns at that falling edge.
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) check("done_timeout", {63'd0, done}, 64'd1);
   endtask

   initial begin
      start = 0; op = 0; rs_val = 0; rt_val = 0; mthi = 0; mtlo = 0; wdata = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_hi", {32'd0, hi}, 64'd0);
      check("reset_lo", {32'd0, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // MULTU all-ones squared, with busy/done framing measured per cycle
      start = 1'b1; op = 2'b01; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
      @(posedge clk);
      busy_cnt = 0; done_cnt = 0; done_idx = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_idx < 0) done_idx = i;
         end
      end
      check("multu_busy_cycles", 64'(busy_cnt), 64'd33);
      check("multu_done_cycles", 64'(done_cnt), 64'd1);
      check("multu_done_cycle_index", 64'(done_idx), 64'd33);
      check("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
      check("multu_lo", {32'd0, lo}, 64'h0000_0001);

      // MULT -3 x 5, then DIV -7 / 2 issued in the done cycle
      launch(2'b00, 32'hFFFF_FFFD, 32'd5);
      wait_done(cyc);
      check("mult_latency", 64'(cyc), 64'd33);
      check("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
      check("mult_lo", {32'd0, lo}, 64'hFFFF_FFF1);
      launch(2'b10, 32'hFFFF_FFF9, 32'd2);
      check("b2b_busy", {63'd0, busy}, 64'd1);
      check("b2b_hi_hold", {32'd0, hi}, 64'hFFFF_FFFF);
      check("b2b_lo_hold", {32'd0, lo}, 64'hFFFF_FFF1);
      wait_done(cyc);
      check("div_latency", 64'(cyc), 64'd33);
      check("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
      check("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
      @(negedge clk);
      check("done_clears", {63'd0, done}, 64'd0);

      // Divide by zero and the overflow case
      launch(2'b11, 32'h64, 32'd0);
      wait_done(cyc);
      check("divu0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
      check("divu0_hi", {32'd0, hi}, 64'h64);
      @(negedge clk);
      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(cyc);
      check("divovf_lo", {32'd0, lo}, 64'h8000_0000);
      check("divovf_hi", {32'd0, hi}, 64'h0);
      @(negedge clk);

      // MULTU 7 x 9 with a stray start and mtlo while busy
      launch(2'b01, 32'd7, 32'd9);
      repeat (3) @(negedge clk);
      start = 1'b1; op = 2'b00; rs_val = 32'd100; rt_val = 32'd100;
      mtlo = 1'b1; wdata = 32'hDEAD;
      @(negedge clk);
      start = 1'b0; mtlo = 1'b0;
      check("run_hi_hold", {32'd0, hi}, 64'h0);
      check("run_lo_hold", {32'd0, lo}, 64'h8000_0000);
      wait_done(cyc);
      check("ignored_hi", {32'd0, hi}, 64'h0);
      check("ignored_lo", {32'd0, lo}, 64'h3F);
      @(negedge clk);
      check("ignored_no_restart", {63'd0, busy}, 64'd0);

      // MTHI in idle
      mthi = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      mthi = 1'b0;
      check("mthi_hi", {32'd0, hi}, 64'h1234);
      check("mthi_lo_unchanged", {32'd0, lo}, 64'h3F);

      // start together with mtlo: start wins
      mtlo = 1'b1; wdata = 32'h1234;
      launch(2'b00, 32'd2, 32'd3);
      mtlo = 1'b0;
      check("start_mtlo_lo_unwritten", {32'd0, lo}, 64'h3F);
      wait_done(cyc);
      check("start_mtlo_lo", {32'd0, lo}, 64'd6);
      check("start_mtlo_hi", {32'd0, hi}, 64'd0);
      @(negedge clk);

      // Asynchronous abort mid-divide, then a clean DIVU
      launch(2'b10, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_hi", {32'd0, hi}, 64'd0);
      check("abort_lo", {32'd0, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      launch(2'b11, 32'd10, 32'd3);
      wait_done(cyc);
      check("divu_latency", 64'(cyc), 64'd33);
      check("divu_lo", {32'd0, lo}, 64'd3);
      check("divu_hi", {32'd0, hi}, 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
